mips_instr_encoder: RTL and testbench

Sequential MIPS instruction encoder and instruction-memory loader. It accepts symbolic instruction requests (operation, register fields, immediate, jump target) over a valid/ready handshake and encodes them into 32-bit MIPS words. It writes those words to consecutive instruction-memory addresses from a programmed base. It produces the same opcode/funct encodings the control unit decodes, and is used by the boot/test path to fill instruction memory before the core runs.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/mips_instr_encoder_if.sv | 21 ++
 rtl/mips_instr_pack.sv | 34 +++
 rtl/mips_instr_encoder.sv | 152 +++++++++++++++
 tb/tb_mips_instr_encoder.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: request ops, opcodes, functs and encoder states.
// The PAD state exists only when ENC_NOP_PAD_EN is defined.
package mips_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_ADDI = 4'd8,
    OP_J    = 4'd9
  } req_op_e;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_J     = 6'h02;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
`ifdef ENC_NOP_PAD_EN
    ST_PAD  = 2'd3,
`endif
    ST_DONE = 2'd2
  } enc_state_e;

  // Ops whose delay slot gets a NOP when padding is enabled.
  function automatic logic is_ctrl_xfer(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request channel of the instruction encoder: symbolic instruction fields plus valid/ready.
interface mips_instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [15:0] req_imm;
  logic [25:0] req_target;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_target,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_target,
    output req_ready
  );
endinterface

// File: rtl/mips_instr_pack.sv
// Combinational field packer: symbolic request -> 32-bit MIPS word plus illegal-op flag.
module mips_instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the instruction format and fixed opcode/funct per op.
  always_comb begin
    word    = NOP_WORD;
    illegal = 1'b0;
    case (op)
      OP_ADD:  word = {OPCODE_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
      OP_SUB:  word = {OPCODE_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB};
      OP_AND:  word = {OPCODE_RTYPE, rs, rt, rd, 5'd0, FUNCT_AND};
      OP_OR:   word = {OPCODE_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR};
      OP_SLT:  word = {OPCODE_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT};
      OP_LW:   word = {OPCODE_LW, rs, rt, imm};
      OP_SW:   word = {OPCODE_SW, rs, rt, imm};
      OP_BEQ:  word = {OPCODE_BEQ, rs, rt, imm};
      OP_ADDI: word = {OPCODE_ADDI, rs, rt, imm};
      OP_J:    word = {OPCODE_J, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Sequential MIPS encoder / instruction-memory loader writing words from base_addr upward.
// Optional ENC_NOP_PAD_EN inserts a NOP after a BEQ or J that is not the last word.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      num_words,
  mips_instr_encoder_if.slave   req,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err_illegal
);

  enc_state_e        state_r;
  logic [ADDR_W-1:0] base_r;
  logic [CNT_W-1:0]  num_r;
  logic [CNT_W-1:0]  count_r;
  logic              ready_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  logic [31:0]       word_s;
  logic              illegal_s;
  logic              accept_s;
  logic [CNT_W-1:0]  next_count_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic              last_s;

  mips_instr_pack u_pack (
    .op      (req.req_op),
    .rs      (req.req_rs),
    .rt      (req.req_rt),
    .rd      (req.req_rd),
    .imm     (req.req_imm),
    .target  (req.req_target),
    .word    (word_s),
    .illegal (illegal_s)
  );

  assign accept_s     = req.req_valid && ready_r;
  assign next_count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
  // Byte address of the current word; the adder wraps naturally at 2^ADDR_W.
  assign wr_addr_s    = base_r + {{(ADDR_W-CNT_W-2){1'b0}}, count_r, 2'b00};
  assign last_s       = (next_count_s == num_r);

  assign req.req_ready = ready_r;
  assign imem_we       = we_r;
  assign imem_addr     = addr_r;
  assign imem_wdata    = wdata_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err_illegal   = err_r;

  // Load-sequence FSM with counter and registered write/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      base_r  <= {ADDR_W{1'b0}};
      num_r   <= {CNT_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= 32'h0000_0000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      we_r   <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            base_r  <= base_addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
            num_r   <= num_words;
            count_r <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            if (num_words == {CNT_W{1'b0}}) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_LOAD;
              ready_r <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            if (illegal_s) begin
              err_r <= 1'b1;
            end else begin
              we_r    <= 1'b1;
              addr_r  <= wr_addr_s;
              wdata_r <= word_s;
              count_r <= next_count_s;
              if (last_s) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
                ready_r <= 1'b0;
              end
`ifdef ENC_NOP_PAD_EN
              else if (is_ctrl_xfer(req.req_op)) begin
                state_r <= ST_PAD;
                ready_r <= 1'b0;
              end
`endif
            end
          end
        end
`ifdef ENC_NOP_PAD_EN
        ST_PAD: begin
          we_r    <= 1'b1;
          addr_r  <= wr_addr_s;
          wdata_r <= NOP_WORD;
          count_r <= next_count_s;
          if (last_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_LOAD;
            ready_r <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: vector table plus hand-written sequences,
// with a write scoreboard; follows ENC_NOP_PAD_EN when it is defined.
module tb_mips_instr_encoder;
  import mips_pkg::*;

  localparam int CNT_W  = 8;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] base;
    logic [31:0] exp_addr;
    logic [31:0] exp_word;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = 32'h0;
  logic [CNT_W-1:0]  num_words = 8'h0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err_illegal;

  mips_instr_encoder_if rif();

  mips_instr_encoder #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .req         (rif),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  last_wr_cyc = -10;
  int  prev_wr_cyc = -20;
  wr_t sb[$];
  vec_t vt[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_t e;
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", imem_addr, e.addr);
        chk("wr_data", imem_wdata, e.data);
        chk("wr_done", 32'(done), 32'(e.last));
      end
    end
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic l);
    sb.push_back('{addr: a, data: d, last: l});
  endtask

  task automatic do_start(input logic [31:0] b, input logic [7:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    bit acc;
    int tries;
    rif.req_valid = 1'b1;
    rif.req_op = op;
    rif.req_rs = rs;
    rif.req_rt = rt;
    rif.req_rd = rd;
    rif.req_imm = imm;
    rif.req_target = tgt;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = (rif.req_ready === 1'b1);
      @(posedge clk); #1;
      tries++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no req_ready expected accept within 50 cycles");
    end
  endtask

  task automatic idle_req();
    rif.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200us");
    $fatal(1);
  end

  initial begin
    vt[0] = '{OP_ADD,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0000000, 32'h0000_0100, 32'h0000_0100, 32'h0022_1820};
    vt[1] = '{OP_SUB,  5'd4,  5'd5,  5'd6,  16'h1234, 26'h0000000, 32'h0000_1000, 32'h0000_1000, 32'h0085_3022};
    vt[2] = '{OP_AND,  5'd7,  5'd8,  5'd9,  16'h0000, 26'h3FFFFFF, 32'h0000_1010, 32'h0000_1010, 32'h00E8_4824};
    vt[3] = '{OP_OR,   5'd31, 5'd31, 5'd31, 16'h0000, 26'h0000000, 32'h0000_1022, 32'h0000_1020, 32'h03FF_F825};
    vt[4] = '{OP_SLT,  5'd10, 5'd11, 5'd12, 16'hFFFF, 26'h1555555, 32'h0000_1030, 32'h0000_1030, 32'h014B_602A};
    vt[5] = '{OP_SW,   5'd29, 5'd31, 5'd5,  16'h8000, 26'h0000000, 32'h0000_1041, 32'h0000_1040, 32'hAFBF_8000};
    vt[6] = '{OP_LW,   5'd29, 5'd8,  5'd0,  16'h0004, 26'h0000000, 32'h0000_1050, 32'h0000_1050, 32'h8FA8_0004};
    vt[7] = '{OP_ADDI, 5'd0,  5'd2,  5'd0,  16'h0005, 26'h0000000, 32'h0000_1060, 32'h0000_1060, 32'h2002_0005};
    vt[8] = '{OP_BEQ,  5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0000000, 32'h0000_1070, 32'h0000_1070, 32'h1022_FFFF};
    vt[9] = '{OP_J,    5'd3,  5'd4,  5'd5,  16'hABCD, 26'h3FFFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0BFF_FFFF};

    rif.req_valid = 1'b0;
    rif.req_op = 4'd0;
    rif.req_rs = 5'd0;
    rif.req_rt = 5'd0;
    rif.req_rd = 5'd0;
    rif.req_imm = 16'h0;
    rif.req_target = 26'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",    32'(imem_we), 32'd0);
    chk("rst_ready", 32'(rif.req_ready), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err_illegal), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_data",  imem_wdata, 32'h0);
    rst_n = 1'b1;

    // Single-word programs over every legal op; branches as last word never pad.
    for (int i = 0; i < 10; i++) begin
      expect_wr(vt[i].exp_addr, vt[i].exp_word, 1'b1);
      do_start(vt[i].base, 8'd1);
      chk("ready_in_load", 32'(rif.req_ready), 32'd1);
      send(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].imm, vt[i].tgt);
      chk("lat_we", 32'(imem_we), 32'd1);
      chk("lat_done", 32'(done), 32'd1);
      idle_req();
      wait_idle();
    end

    // Back-to-back requests write on consecutive cycles.
    expect_wr(32'h0000_0100, 32'h8FA8_0004, 1'b0);
    expect_wr(32'h0000_0104, 32'h2002_0005, 1'b1);
    do_start(32'h0000_0100, 8'd2);
    send(OP_LW, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
    send(OP_ADDI, 5'd0, 5'd2, 5'd0, 16'h0005, 26'h0);
    idle_req();
    wait_idle();
    chk("b2b_gap", 32'(last_wr_cyc - prev_wr_cyc), 32'd1);

    // Address wraps past the top of the space.
    expect_wr(32'hFFFF_FFFC, 32'h0022_1825, 1'b0);
    expect_wr(32'h0000_0000, 32'h0064_2822, 1'b1);
    do_start(32'hFFFF_FFFE, 8'd2);
    send(OP_OR, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(OP_SUB, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0);
    idle_req();
    wait_idle();

`ifdef ENC_NOP_PAD_EN
    expect_wr(32'h0000_0200, 32'h1022_FFFF, 1'b0);
    expect_wr(32'h0000_0204, 32'h0000_0000, 1'b0);
    expect_wr(32'h0000_0208, 32'h0810_0000, 1'b1);
    do_start(32'h0000_0200, 8'd3);
    send(OP_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    chk("pad_ready", 32'(rif.req_ready), 32'd0);
    send(OP_J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
    idle_req();
    wait_idle();
`else
    expect_wr(32'h0000_0200, 32'h1022_FFFF, 1'b0);
    expect_wr(32'h0000_0204, 32'h0810_0000, 1'b1);
    do_start(32'h0000_0200, 8'd2);
    send(OP_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    chk("nopad_ready", 32'(rif.req_ready), 32'd1);
    send(OP_J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
    idle_req();
    wait_idle();
    chk("nopad_gap", 32'(last_wr_cyc - prev_wr_cyc), 32'd1);
`endif

    // Illegal op: accepted, flagged, not written.
    expect_wr(32'h0000_0300, 32'h0022_1820, 1'b1);
    do_start(32'h0000_0300, 8'd1);
    send(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    chk("illegal_err", 32'(err_illegal), 32'd1);
    chk("illegal_no_we", 32'(imem_we), 32'd0);
    chk("illegal_ready", 32'(rif.req_ready), 32'd1);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    idle_req();
    wait_idle();
    chk("err_sticky", 32'(err_illegal), 32'd1);

    // Zero-length program: done pulse without a write; start clears the error.
    do_start(32'h0000_0400, 8'd0);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_we", 32'(imem_we), 32'd0);
    chk("n0_err_cleared", 32'(err_illegal), 32'd0);
    @(posedge clk); #1;
    chk("n0_done_pulse", 32'(done), 32'd0);
    chk("n0_busy", 32'(busy), 32'd0);

    // Reset mid-sequence after two of four writes.
    expect_wr(32'h0000_0500, 32'h0022_1820, 1'b0);
    expect_wr(32'h0000_0504, 32'h0085_3022, 1'b0);
    do_start(32'h0000_0500, 8'd4);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(OP_SUB, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    idle_req();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_we",    32'(imem_we), 32'd0);
    chk("abort_ready", 32'(rif.req_ready), 32'd0);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_done",  32'(done), 32'd0);
    chk("abort_addr",  imem_addr, 32'h0);
    chk("abort_data",  imem_wdata, 32'h0);
    rif.req_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rif.req_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_abort_busy", 32'(busy), 32'd0);
    chk("post_abort_sb", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
